neuron_feeder: RTL

NEURON_FEEDER -- requirements
Module: neuron_feeder

---
 rtl/neuron_feeder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/neuron_feeder.sv
// neuron_feeder: sequences one neuron evaluation around an external MAC.
// It clears the MAC, streams K weight/input pairs from two synchronous-read
// memories, lets the MAC fold in the bias, then captures the MAC result
// with an optional ReLU. The result is presented on y with a one-cycle y_valid.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, bias          begin an evaluation (accepted only in IDLE), bias operand
//   w_addr, x_addr       memory read addresses (identical)
//   w_rdata, x_rdata     memory read data, one cycle after the address
//   n_rst                synchronous clear to the MAC
//   n_inptReady          MAC accumulate strobe
//   n_w, n_x, n_b        MAC operands
//   n_out                MAC result (combinational from its accumulator)
//   busy                 evaluation in progress
//   y, y_valid           captured result and its one-cycle strobe
//   state_dbg            current FSM state encoding
//
// Handshake: there is no back-pressure. start is a request that is honoured
// only while IDLE; y_valid is a single-cycle pulse and y holds until the
// next capture.
module neuron_feeder #(
    parameter int N    = 10,
    parameter int Q    = 8,
    parameter int K    = 8,
    parameter int AW   = (K > 1) ? $clog2(K) : 1,
    parameter int RELU = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  bias,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] x_addr,
    input  logic [N-1:0]  w_rdata,
    input  logic [N-1:0]  x_rdata,
    output logic          n_rst,
    output logic          n_inptReady,
    output logic [N-1:0]  n_w,
    output logic [N-1:0]  n_x,
    output logic [N-1:0]  n_b,
    input  logic [N-1:0]  n_out,
    output logic          busy,
    output logic [N-1:0]  y,
    output logic          y_valid,
    output logic [2:0]    state_dbg
);

    // The bias is handed over unshifted; the MAC aligns it by Q fractional
    // bits, so Q must leave at least one integer (sign) bit.
    if (Q >= N || K < 1) begin : g_bad_params
        $error("neuron_feeder: require Q < N and K >= 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        STREAM  = 3'd2,
        DRAIN   = 3'd3,
        BIAS    = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  n_b_q,   n_b_d;
    logic [N-1:0]  y_q,     y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            n_b_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            n_b_q   <= n_b_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        n_b_d   = n_b_q;
        y_d     = y_q;
        // The memory answers one cycle after the address, so the strobe is
        // the address-valid flag delayed by one register.
        valid_d = (state_q == STREAM);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    n_b_d   = bias;
                end
            end
            CLEAR: begin
                state_d = STREAM;
                addr_d  = '0;
            end
            STREAM: begin
                // Exactly K addresses; return to 0 instead of wrapping.
                if (addr_q == AW'(K - 1)) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            DRAIN:   state_d = BIAS;
            BIAS:    state_d = CAPTURE;
            CAPTURE: begin
                y_d     = (RELU != 0 && n_out[N-1]) ? '0 : n_out;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign w_addr      = addr_q;
    assign x_addr      = addr_q;
    assign n_rst       = (state_q == IDLE) || (state_q == CLEAR);
    assign n_inptReady = valid_q;
    assign n_w         = w_rdata;
    assign n_x         = x_rdata;
    assign n_b         = n_b_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign y           = y_q;
    assign y_valid     = (state_q == DONE);
    assign state_dbg   = state_q;

endmodule
